if_fetch: RTL

Instruction fetch stage of the pipelined MIPS core, directly upstream of the instruction decoder. Maintains the PC, issues word reads to instruction memory over a req/ack handshake with one outstanding request, and buffers returned words with their PCs in a small FIFO. Presents instruction/PC pairs to decode through a valid/ready handshake. Accepts a branch/jump redirect that flushes all buffered and in-flight fetches.

---
 rtl/pipeline_pkg.sv | 22 ++
 rtl/fetch_fifo.sv | 83 ++++++++
 rtl/if_fetch.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_pkg
//  Description : Shared definitions for the MIPS pipeline front end:
//                default datapath widths, PC increment and the fetch
//                state encoding used by if_fetch.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

    localparam int INSTR_SIZE = 32;
    localparam int ADDR_SIZE  = 32;
    localparam int PC_STEP    = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : Parametric synchronous FIFO holding {instruction, pc}
//                entries between instruction memory and decode. The head
//                entry is presented combinationally from the storage array.
//                A clear input empties the FIFO in one cycle and overrides
//                any push or pop in the same cycle.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                clear         - drop all entries
//                push/push_data- write one entry
//                pop           - remove head entry (ignored when empty)
//                head_data     - current head entry
//                count         - number of stored entries (0..DEPTH)
//                not_empty     - count != 0
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     not_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_pop;
    logic w_do_push;

    // Guard both sides so a misbehaving producer or consumer can never
    // corrupt the pointers.
    assign w_do_pop  = pop && (r_count != '0);
    assign w_do_push = push && ((r_count != c_DEPTH) || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign head_data = r_mem[r_rd_ptr];
    assign count     = r_count;
    assign not_empty = (r_count != '0);

endmodule
`default_nettype wire

// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch
//  Description : Instruction fetch stage. Keeps the PC, reads instruction
//                memory with a req/ack handshake (one outstanding request),
//                buffers returned words with their PCs and hands them to
//                decode over valid/ready. A redirect flushes the buffer and
//                any in-flight read and restarts fetch at redirect_pc.
//  Ports       : clk, rst               - clock, synchronous active-high reset
//                imem_req/imem_addr     - read request, held until imem_ack
//                imem_ack/imem_rdata    - read completion and data
//                redirect/redirect_pc   - flush and new fetch PC
//                instr/instr_pc         - head instruction and its PC
//                instr_valid/instr_ready- decode handshake
//  Revision    : 1.0 - initial release
// ============================================================================
module if_fetch #(
    parameter int                   INSTR_SIZE = pipeline_pkg::INSTR_SIZE,
    parameter int                   ADDR_SIZE  = pipeline_pkg::ADDR_SIZE,
    parameter int                   FIFO_DEPTH = 2,
    parameter logic [ADDR_SIZE-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [ADDR_SIZE-1:0]  imem_addr,
    input  logic                  imem_ack,
    input  logic [INSTR_SIZE-1:0] imem_rdata,
    input  logic                  redirect,
    input  logic [ADDR_SIZE-1:0]  redirect_pc,
    output logic [INSTR_SIZE-1:0] instr,
    output logic [ADDR_SIZE-1:0]  instr_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready
);

    import pipeline_pkg::*;

    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int ENTRY_W = INSTR_SIZE + ADDR_SIZE;

    localparam logic [CNT_W-1:0]     c_DEPTH      = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_SIZE-1:0] c_STEP       = ADDR_SIZE'(PC_STEP);
    localparam logic [ADDR_SIZE-1:0] c_ALIGN_MASK = ~ADDR_SIZE'(3);

    fetch_state_t r_state;
    fetch_state_t w_state_next;
    logic [ADDR_SIZE-1:0] r_pc;
    logic [ADDR_SIZE-1:0] w_pc_next;
    logic [ADDR_SIZE-1:0] r_addr;
    logic [ADDR_SIZE-1:0] w_addr_next;

    logic                 w_push;
    logic                 w_pop;
    logic [CNT_W-1:0]     w_count;
    logic [CNT_W-1:0]     w_count_after;
    logic                 w_valid;
    logic [ENTRY_W-1:0]   w_head;
    logic [ADDR_SIZE-1:0] w_redirect_pc;
    logic [ADDR_SIZE-1:0] w_seq_addr;

    assign w_pop         = w_valid && instr_ready;
    assign w_redirect_pc = redirect_pc & c_ALIGN_MASK;
    assign w_seq_addr    = r_addr + c_STEP;  // wraps modulo 2^ADDR_SIZE

    // Occupancy after this cycle's push/pop; only meaningful in WAIT,
    // where count never exceeds FIFO_DEPTH-1, so count+1 cannot overflow.
    assign w_count_after = w_count + CNT_W'(1) - CNT_W'(w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_pc    <= RESET_PC;
            r_addr  <= RESET_PC;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_addr  <= w_addr_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_addr_next  = r_addr;
        w_push       = 1'b0;
        case (r_state)
            IDLE: begin
                if (redirect) begin
                    w_pc_next = w_redirect_pc;
                end else if (w_count < c_DEPTH) begin
                    w_state_next = WAIT;
                    w_addr_next  = r_pc;
                end
            end
            WAIT: begin
                if (redirect) begin
                    // The request cannot be withdrawn: if it has not
                    // completed yet, wait it out and drop its data.
                    w_pc_next    = w_redirect_pc;
                    w_state_next = imem_ack ? IDLE : DISCARD;
                end else if (imem_ack) begin
                    w_push    = 1'b1;
                    w_pc_next = w_seq_addr;
                    if (w_count_after < c_DEPTH) begin
                        w_addr_next = w_seq_addr;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            DISCARD: begin
                if (redirect) begin
                    w_pc_next = w_redirect_pc;
                end
                if (imem_ack) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fetch_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect),
        .push      (w_push),
        .push_data ({imem_rdata, r_addr}),
        .pop       (w_pop),
        .head_data (w_head),
        .count     (w_count),
        .not_empty (w_valid)
    );

    assign imem_req    = (r_state == WAIT) || (r_state == DISCARD);
    assign imem_addr   = r_addr;
    assign instr       = w_head[ENTRY_W-1:ADDR_SIZE];
    assign instr_pc    = w_head[ADDR_SIZE-1:0];
    assign instr_valid = w_valid;

endmodule
`default_nettype wire
